// File: rtl/rob_pkg.sv
// Shared encodings for the reorder buffer: entry types and the default tag width.
package rob_pkg;

  localparam int ROB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ROB_T_REG    = 2'd0,
    ROB_T_BRANCH = 2'd1,
    ROB_T_STORE  = 2'd2,
    ROB_T_RSVD   = 2'd3
  } rob_type_e;

endpackage

// File: rtl/rob_bypass_mux.sv
// Operand lookup for one query port: a same-cycle result broadcast overrides the stored entry.
module rob_bypass_mux
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic [ROB_WIDTH-1:0] query_tag,
  input  logic                 stored_ready,
  input  logic [31:0]          stored_value,
  input  logic                 done_alu_1,
  input  logic [ROB_WIDTH-1:0] tag_alu_1,
  input  logic [31:0]          value_alu_1,
  input  logic                 done_alu_2,
  input  logic [ROB_WIDTH-1:0] tag_alu_2,
  input  logic [31:0]          value_alu_2,
  input  logic                 done_lsb,
  input  logic [ROB_WIDTH-1:0] tag_lsb,
  input  logic [31:0]          value_lsb,
  output logic                 ready,
  output logic [31:0]          value
);

  // Lowest priority first so that ALU1 ends up winning any collision.
  always_comb begin
    ready = stored_ready;
    value = stored_value;
    if (done_lsb && tag_lsb == query_tag) begin
      ready = 1'b1;
      value = value_lsb;
    end
    if (done_alu_2 && tag_alu_2 == query_tag) begin
      ready = 1'b1;
      value = value_alu_2;
    end
    if (done_alu_1 && tag_alu_1 == query_tag) begin
      ready = 1'b1;
      value = value_alu_1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags, captures results, retires in order and
// flushes on a branch mispredicted at commit. Handshake: an issue is accepted on an edge when
// rdy_in & issue & ~full & ~clear_signal; a commit happens on an edge when commit_valid is high.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT,
  parameter int ROB_SIZE  = 2 ** ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 full,
  input  logic [ROB_WIDTH-1:0] query_tag_1,
  input  logic [ROB_WIDTH-1:0] query_tag_2,
  output logic                 query_ready_1,
  output logic                 query_ready_2,
  output logic [31:0]          query_value_1,
  output logic [31:0]          query_value_2,
  input  logic                 done_alu_1,
  input  logic                 done_alu_2,
  input  logic                 done_lsb,
  input  logic [ROB_WIDTH-1:0] tag_alu_1,
  input  logic [ROB_WIDTH-1:0] tag_alu_2,
  input  logic [ROB_WIDTH-1:0] tag_lsb,
  input  logic [31:0]          value_alu_1,
  input  logic [31:0]          value_alu_2,
  input  logic [31:0]          value_lsb,
  output logic                 commit_valid,
  output logic [1:0]           commit_type,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic                 clear_signal,
  output logic [31:0]          redirect_pc,
  output logic [ROB_WIDTH:0]   count
);

  localparam logic [ROB_WIDTH:0] SIZE_C = (ROB_WIDTH + 1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  ready;
  rob_type_e            type_q  [ROB_SIZE];
  logic [4:0]           rd_q    [ROB_SIZE];
  logic                 pred_q  [ROB_SIZE];
  logic [31:0]          alt_pc_q[ROB_SIZE];
  logic [31:0]          value_q [ROB_SIZE];
  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;

  rob_type_e issue_kind;
  logic      head_done;
  logic      mispredict;
  logic      do_issue;
  logic      res_en;
  logic      wr_alu_1, wr_alu_2, wr_lsb;

  always_comb begin
    issue_kind = (issue_type == 2'd3) ? ROB_T_REG : rob_type_e'(issue_type);
  end

  assign head_done  = busy[head] & ready[head];
  assign mispredict = rdy_in & head_done & (type_q[head] == ROB_T_BRANCH)
                    & (value_q[head][0] != pred_q[head]);
  assign full       = (count == SIZE_C);
  assign do_issue   = rdy_in & issue & ~full & ~mispredict;
  assign res_en     = rdy_in & ~mispredict;
  assign wr_alu_1   = res_en & done_alu_1 & busy[tag_alu_1] & ~ready[tag_alu_1];
  assign wr_alu_2   = res_en & done_alu_2 & busy[tag_alu_2] & ~ready[tag_alu_2];
  assign wr_lsb     = res_en & done_lsb & busy[tag_lsb] & ~ready[tag_lsb];

  assign issue_tag    = tail;
  assign clear_signal = mispredict;
  assign redirect_pc  = mispredict ? alt_pc_q[head] : 32'd0;
  assign commit_valid = rdy_in & head_done & ~mispredict;
  assign commit_type  = commit_valid ? type_q[head] : 2'd0;
  assign commit_rd    = commit_valid ? rd_q[head] : 5'd0;
  assign commit_value = commit_valid ? value_q[head] : 32'd0;
  assign commit_tag   = commit_valid ? head : '0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (rdy_in) begin
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        if (wr_alu_1) ready[tag_alu_1] <= 1'b1;
        if (wr_alu_2) ready[tag_alu_2] <= 1'b1;
        if (wr_lsb)   ready[tag_lsb]   <= 1'b1;
        if (commit_valid) begin
          busy[head] <= 1'b0;
          head       <= head + ROB_WIDTH'(1);
        end
        // Tail never equals head while an issue is accepted and the head commits.
        if (do_issue) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= (issue_kind == ROB_T_STORE);
          tail        <= tail + ROB_WIDTH'(1);
        end
        case ({do_issue, commit_valid})
          2'b10:   count <= count + (ROB_WIDTH + 1)'(1);
          2'b01:   count <= count - (ROB_WIDTH + 1)'(1);
          default: ;
        endcase
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind busy/ready.
  always_ff @(posedge clk_in) begin
    if (wr_lsb)   value_q[tag_lsb]   <= value_lsb;
    if (wr_alu_2) value_q[tag_alu_2] <= value_alu_2;
    if (wr_alu_1) value_q[tag_alu_1] <= value_alu_1;
    if (do_issue) begin
      type_q[tail]   <= issue_kind;
      rd_q[tail]     <= issue_rd;
      pred_q[tail]   <= issue_pred_taken;
      alt_pc_q[tail] <= issue_alt_pc;
      value_q[tail]  <= 32'd0;
    end
  end

  rob_bypass_mux #(.ROB_WIDTH(ROB_WIDTH)) u_bypass_1 (
    .query_tag    (query_tag_1),
    .stored_ready (busy[query_tag_1] & ready[query_tag_1]),
    .stored_value (value_q[query_tag_1]),
    .done_alu_1   (done_alu_1),
    .tag_alu_1    (tag_alu_1),
    .value_alu_1  (value_alu_1),
    .done_alu_2   (done_alu_2),
    .tag_alu_2    (tag_alu_2),
    .value_alu_2  (value_alu_2),
    .done_lsb     (done_lsb),
    .tag_lsb      (tag_lsb),
    .value_lsb    (value_lsb),
    .ready        (query_ready_1),
    .value        (query_value_1)
  );

  rob_bypass_mux #(.ROB_WIDTH(ROB_WIDTH)) u_bypass_2 (
    .query_tag    (query_tag_2),
    .stored_ready (busy[query_tag_2] & ready[query_tag_2]),
    .stored_value (value_q[query_tag_2]),
    .done_alu_1   (done_alu_1),
    .tag_alu_1    (tag_alu_1),
    .value_alu_1  (value_alu_1),
    .done_alu_2   (done_alu_2),
    .tag_alu_2    (tag_alu_2),
    .value_alu_2  (value_alu_2),
    .done_lsb     (done_lsb),
    .tag_lsb      (tag_lsb),
    .value_lsb    (value_lsb),
    .ready        (query_ready_2),
    .value        (query_value_2)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, issue, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_alt_pc;
  logic [3:0]  issue_tag, query_tag_1, query_tag_2, tag_alu_1, tag_alu_2, tag_lsb, commit_tag;
  logic        full, query_ready_1, query_ready_2;
  logic [31:0] query_value_1, query_value_2, value_alu_1, value_alu_2, value_lsb;
  logic        done_alu_1, done_alu_2, done_lsb;
  logic        commit_valid, clear_signal;
  logic [1:0]  commit_type;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, redirect_pc;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt;
    logic [31:0] val;
    logic        rdy;
  } ent_t;

  ent_t       rob_q[$];   // in-flight instructions, oldest first
  logic [3:0] next_tag;
  logic [3:0] exp_q[$];   // tags expected to retire, in program order

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue(issue), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_tag(issue_tag), .full(full),
    .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
    .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
    .query_value_1(query_value_1), .query_value_2(query_value_2),
    .done_alu_1(done_alu_1), .done_alu_2(done_alu_2), .done_lsb(done_lsb),
    .tag_alu_1(tag_alu_1), .tag_alu_2(tag_alu_2), .tag_lsb(tag_lsb),
    .value_alu_1(value_alu_1), .value_alu_2(value_alu_2), .value_lsb(value_lsb),
    .commit_valid(commit_valid), .commit_type(commit_type), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .clear_signal(clear_signal), .redirect_pc(redirect_pc), .count(count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rdy_in = 1'b1; issue = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
    issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
    query_tag_1 = 4'd0; query_tag_2 = 4'd0;
    done_alu_1 = 1'b0; done_alu_2 = 1'b0; done_lsb = 1'b0;
    tag_alu_1 = 4'd0; tag_alu_2 = 4'd0; tag_lsb = 4'd0;
    value_alu_1 = 32'd0; value_alu_2 = 32'd0; value_lsb = 32'd0;
  endtask

  task automatic drive_issue(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                             input logic [31:0] alt);
    issue = 1'b1; issue_type = t; issue_rd = rd; issue_pred_taken = pred; issue_alt_pc = alt;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    rob_q.delete();
    exp_q.delete();
    next_tag = 4'd0;
    check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    check("rst_clear", {31'd0, clear_signal}, 32'd0);
    check("rst_issue_tag", {28'd0, issue_tag}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic int find(input logic [3:0] t);
    for (int i = 0; i < rob_q.size(); i++)
      if (rob_q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic check_query(input string nm, input logic [3:0] qt,
                             input logic got_r, input logic [31:0] got_v);
    logic        er;
    logic [31:0] ev;
    int          idx;
    er = 1'b0; ev = 32'd0;
    idx = find(qt);
    if (idx >= 0 && rob_q[idx].rdy) begin er = 1'b1; ev = rob_q[idx].val; end
    if (done_lsb   && tag_lsb   == qt) begin er = 1'b1; ev = value_lsb;   end
    if (done_alu_2 && tag_alu_2 == qt) begin er = 1'b1; ev = value_alu_2; end
    if (done_alu_1 && tag_alu_1 == qt) begin er = 1'b1; ev = value_alu_1; end
    check({nm, "_ready"}, {31'd0, got_r}, {31'd0, er});
    if (er) check({nm, "_value"}, got_v, ev);
  endtask

  task automatic apply_result(input logic d, input logic [3:0] t, input logic [31:0] v);
    int idx;
    idx = find(t);
    if (d && idx >= 0 && !rob_q[idx].rdy) begin
      rob_q[idx].rdy = 1'b1;
      rob_q[idx].val = v;
    end
  endtask

  // One clock: check combinational outputs against the model, advance the model, clock the DUT.
  task automatic step();
    logic head_ok, mis, cv, fl;
    ent_t e;
    #1;
    head_ok = rob_q.size() > 0 && rob_q[0].rdy;
    mis = rdy_in && head_ok && rob_q[0].typ == 2'd1 && (rob_q[0].val[0] != rob_q[0].pred);
    cv  = rdy_in && head_ok && !mis;
    fl  = rob_q.size() == 16;
    check("issue_tag", {28'd0, issue_tag}, {28'd0, next_tag});
    check("full", {31'd0, full}, {31'd0, fl});
    check("count", {27'd0, count}, rob_q.size());
    check("commit_valid", {31'd0, commit_valid}, {31'd0, cv});
    check("clear_signal", {31'd0, clear_signal}, {31'd0, mis});
    if (mis) check("redirect_pc", redirect_pc, rob_q[0].alt);
    if (cv) begin
      check("commit_tag", {28'd0, commit_tag}, {28'd0, exp_q[0]});
      check("commit_type", {30'd0, commit_type}, {30'd0, rob_q[0].typ});
      check("commit_rd", {27'd0, commit_rd}, {27'd0, rob_q[0].rd});
      if (rob_q[0].typ != 2'd2) check("commit_value", commit_value, rob_q[0].val);
    end
    check_query("q1", query_tag_1, query_ready_1, query_value_1);
    check_query("q2", query_tag_2, query_ready_2, query_value_2);
    if (rdy_in) begin
      if (mis) begin
        rob_q.delete();
        exp_q.delete();
        next_tag = 4'd0;
      end else begin
        apply_result(done_alu_1, tag_alu_1, value_alu_1);
        apply_result(done_alu_2, tag_alu_2, value_alu_2);
        apply_result(done_lsb, tag_lsb, value_lsb);
        if (cv) begin
          void'(rob_q.pop_front());
          void'(exp_q.pop_front());
        end
        if (issue && !fl) begin
          e.tag = next_tag;
          e.typ = (issue_type == 2'd3) ? 2'd0 : issue_type;
          e.rd = issue_rd; e.pred = issue_pred_taken; e.alt = issue_alt_pc;
          e.val = 32'd0; e.rdy = (e.typ == 2'd2);
          rob_q.push_back(e);
          exp_q.push_back(next_tag);
          next_tag = next_tag + 4'd1;
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
    drive_idle();
  endtask

  function automatic logic [3:0] pick_tag();
    if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
      return rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
    return 4'($urandom_range(0, 15));
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    drive_idle();
    rst_in = 1'b0;
    next_tag = 4'd0;
    @(negedge clk_in);

    // Fill to capacity, then one rejected issue.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_issue(2'd0, 5'(i), 1'b0, 32'd0);
      step();
    end
    step();

    // Out-of-order results, in-order retirement.
    do_reset();
    drive_issue(2'd0, 5'd1, 1'b0, 32'd0); step();
    drive_issue(2'd0, 5'd2, 1'b0, 32'd0); step();
    done_alu_2 = 1'b1; tag_alu_2 = 4'd1; value_alu_2 = 32'h55; step();
    done_alu_1 = 1'b1; tag_alu_1 = 4'd0; value_alu_1 = 32'hAA; step();
    step(); step(); step();

    // Same-cycle bypass, with a collision resolved in favour of ALU1.
    do_reset();
    for (int i = 0; i < 4; i++) begin drive_issue(2'd0, 5'd3, 1'b0, 32'd0); step(); end
    query_tag_1 = 4'd3; done_lsb = 1'b1; tag_lsb = 4'd3; value_lsb = 32'h1234; step();
    query_tag_2 = 4'd2; done_lsb = 1'b1; tag_lsb = 4'd2; value_lsb = 32'h9;
    done_alu_1 = 1'b1; tag_alu_1 = 4'd2; value_alu_1 = 32'h77; step();
    query_tag_1 = 4'd2; query_tag_2 = 4'd3; step();

    // Mispredicted branch flushes; an issue in the flush cycle is dropped.
    do_reset();
    drive_issue(2'd1, 5'd0, 1'b1, 32'h100); step();
    drive_issue(2'd0, 5'd4, 1'b0, 32'd0); step();
    done_alu_1 = 1'b1; tag_alu_1 = 4'd0; value_alu_1 = 32'd0; step();
    drive_issue(2'd0, 5'd5, 1'b0, 32'd0); step();
    step();

    // Store behind a pending register write.
    do_reset();
    drive_issue(2'd0, 5'd6, 1'b0, 32'd0); step();
    drive_issue(2'd2, 5'd0, 1'b0, 32'd0); step();
    step(); step();
    done_alu_1 = 1'b1; tag_alu_1 = 4'd0; value_alu_1 = 32'h7; step();
    step(); step(); step();

    // Asynchronous reset mid-stream, then a stall with rdy_in low.
    for (int i = 0; i < 5; i++) begin drive_issue(2'd0, 5'd7, 1'b0, 32'd0); step(); end
    do_reset();
    for (int i = 0; i < 3; i++) begin drive_issue(2'd0, 5'd8, 1'b0, 32'd0); step(); end
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0;
      drive_issue(2'd0, 5'd9, 1'b0, 32'd0);
      done_alu_1 = 1'b1; tag_alu_1 = 4'd0; value_alu_1 = 32'h3;
      step();
    end
    step(); step(); step();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) != 0) begin
        drive_issue(2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom),
                    $urandom);
        if ($urandom_range(0, 9) != 0 && issue_type == 2'd1) issue_type = 2'd0;
      end
      query_tag_1 = pick_tag();
      query_tag_2 = pick_tag();
      if ($urandom_range(0, 1) != 0) begin
        done_alu_1 = 1'b1; tag_alu_1 = pick_tag(); value_alu_1 = $urandom;
      end
      if ($urandom_range(0, 1) != 0) begin
        done_alu_2 = 1'b1; tag_alu_2 = pick_tag(); value_alu_2 = $urandom;
        if (done_alu_1 && tag_alu_2 == tag_alu_1) done_alu_2 = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        done_lsb = 1'b1; tag_lsb = pick_tag(); value_lsb = $urandom;
      end
      step();
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
